// File: rtl/rr_merge_arbiter.sv
// rtl/rr_merge_arbiter.sv - round-robin N-to-1 merge scheduler with per-source ack timeout
module rr_merge_arbiter #(
    parameter int data_width = 32,
    parameter int num_inputs = 4,
    parameter int src_width  = 2,
    parameter int timeout    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [num_inputs-1:0]            req_l,
    input  logic [num_inputs-1:0]            ack_l,
    input  logic [data_width*num_inputs-1:0] din,
    input  logic                             req_r,
    output logic                             ack_r,
    output logic [data_width-1:0]            dout,
    output logic [src_width-1:0]             dout_src
);

    localparam int cnt_width = (timeout > 255) ? $clog2(timeout + 1) : 8;
    localparam logic [cnt_width-1:0] cnt_last = cnt_width'((timeout > 0) ? timeout - 1 : 0);
    localparam logic [src_width-1:0] ptr_last = src_width'(num_inputs - 1);

    typedef enum logic [1:0] {IDLE, REQ, GRACE, SEND} state_t;

    state_t                state, state_nxt;
    logic [src_width-1:0]  ptr, ptr_nxt, ptr_inc;
    logic [cnt_width-1:0]  cnt, cnt_nxt;
    logic [data_width-1:0] buf_data, din_sel;
    logic [src_width-1:0]  buf_src;
    logic [num_inputs-1:0] req_nxt;
    logic                  ack_sel, capture, send;

    // Explicit wrap so non-power-of-two source counts never visit unused indices
    assign ptr_inc = (ptr == ptr_last) ? '0 : ptr + 1'b1;

    always_comb begin
        din_sel = '0;
        ack_sel = 1'b0;
        for (int i = 0; i < num_inputs; i++) begin
            if (ptr == src_width'(i)) begin
                din_sel = din[data_width*i +: data_width];
                ack_sel = ack_l[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        send      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = REQ;
                cnt_nxt   = '0;
            end
            REQ: begin
                if (cnt != '1) cnt_nxt = cnt + 1'b1;
                if (ack_sel) begin
                    capture   = 1'b1;
                    state_nxt = SEND;
                end else if (timeout != 0 && cnt == cnt_last) begin
                    state_nxt = GRACE;
                end
            end
            GRACE: begin
                // A source that saw req_l before it dropped may still answer here
                if (ack_sel) begin
                    capture   = 1'b1;
                    state_nxt = SEND;
                end else begin
                    ptr_nxt   = ptr_inc;
                    cnt_nxt   = '0;
                    state_nxt = REQ;
                end
            end
            SEND: begin
                if (req_r && !ack_r) begin
                    send      = 1'b1;
                    ptr_nxt   = ptr_inc;
                    cnt_nxt   = '0;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_nxt = '0;
        for (int i = 0; i < num_inputs; i++) begin
            req_nxt[i] = (state_nxt == REQ) && (ptr_nxt == src_width'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            req_l    <= '0;
            ack_r    <= 1'b0;
            dout     <= '0;
            dout_src <= '0;
            buf_data <= '0;
            buf_src  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            req_l <= req_nxt;
            ack_r <= send;
            if (capture) begin
                buf_data <= din_sel;
                buf_src  <= ptr;
            end
            if (send) begin
                dout     <= buf_data;
                dout_src <= buf_src;
            end
        end
    end

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// tb/tb_rr_merge_arbiter.sv - self-checking bench for rr_merge_arbiter
module tb_rr_merge_arbiter;

    localparam int DW = 32;
    localparam int NI = 4;
    localparam int SW = 2;
    localparam int TO = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NI-1:0]    req_l, ack_l;
    logic [DW*NI-1:0] din;
    logic             req_r, ack_r;
    logic [DW-1:0]    dout;
    logic [SW-1:0]    dout_src;

    logic [2:0]       req3, ack3, seen3;
    logic [DW*3-1:0]  din3;
    logic             ack_r3;
    logic [DW-1:0]    dout3;
    logic [1:0]       dout_src3;
    int               exp3 = 0;

    always #5 clk = ~clk;

    rr_merge_arbiter #(.data_width(DW), .num_inputs(NI), .src_width(SW), .timeout(TO)) dut (
        .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
        .req_r(req_r), .ack_r(ack_r), .dout(dout), .dout_src(dout_src)
    );

    rr_merge_arbiter #(.data_width(DW), .num_inputs(3), .src_width(2), .timeout(TO)) dut3 (
        .clk(clk), .rst(rst), .req_l(req3), .ack_l(ack3), .din(din3),
        .req_r(1'b1), .ack_r(ack_r3), .dout(dout3), .dout_src(dout_src3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int idx(input logic [NI-1:0] v);
        for (int i = 0; i < NI; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Producers: value per source, ack delay in polled cycles (0 = never), or random mode
    int unsigned val[NI];
    int          delay[NI];
    int          seen_cnt[NI];
    bit          rnd_mode;
    logic [NI-1:0] req_seen = '0;

    always_comb begin
        for (int i = 0; i < NI; i++) din[i*DW +: DW] = DW'(val[i]);
    end

    // Model: words accepted by producers must appear downstream once each, in acceptance order
    logic [DW-1:0] sb_data[$];
    logic [SW-1:0] sb_src[$];
    logic [DW-1:0] got_data[$];
    int            got_src[$];
    logic [DW-1:0] last_data = '0;
    logic [SW-1:0] last_src = '0;
    logic [NI-1:0] prev_req = '0;
    logic          prev_ack = 1'b0;
    logic          rst_edge = 1'b0;
    int            next_poll = 0, req_len = 0, cyc = 0, last_ack_cyc = 0, last_gap = 0;
    int            done_len[NI];

    always @(posedge clk) rst_edge <= rst;

    always @(negedge clk) begin
        cyc++;
        if (rst_edge) begin
            chk("rst_req_l", req_l, 0);
            chk("rst_ack_r", ack_r, 0);
            chk("rst_dout", dout, 0);
            chk("rst_dout_src", dout_src, 0);
            sb_data.delete();
            sb_src.delete();
            last_data = '0;
            last_src  = '0;
            next_poll = 0;
            prev_req  = '0;
            req_len   = 0;
            prev_ack  = 1'b0;
            exp3      = 0;
        end else begin
            chk("ack_r_pulse", prev_ack & ack_r, 0);
            if (ack_r) begin
                chk("sb_nonempty", sb_data.size() > 0, 1);
                if (sb_data.size() > 0) begin
                    last_data = sb_data.pop_front();
                    last_src  = sb_src.pop_front();
                end
                last_gap     = cyc - last_ack_cyc;
                last_ack_cyc = cyc;
                got_data.push_back(dout);
                got_src.push_back(int'(dout_src));
            end
            chk("dout", dout, last_data);
            chk("dout_src", dout_src, last_src);
            chk("req_onehot", $countones(req_l) <= 1, 1);
            if (req_l != '0) begin
                if (prev_req == '0) begin
                    chk("poll_order", idx(req_l), next_poll);
                    next_poll = (idx(req_l) + 1) % NI;
                    req_len   = 1;
                end else begin
                    chk("req_stable", req_l, prev_req);
                    req_len++;
                end
                chk("req_len_bound", req_len <= TO, 1);
            end else if (prev_req != '0) begin
                done_len[idx(prev_req)] = req_len;
            end
            prev_req = req_l;
            prev_ack = ack_r;
            if (ack_r3) begin
                chk("n3_src", dout_src3, exp3);
                chk("n3_data", dout3, 3 + 2 * exp3);
                exp3 = (exp3 + 1) % 3;
            end
        end

        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                ack_l[i]    = 1'b0;
                seen_cnt[i] = 0;
            end else if (ack_l[i]) begin
                ack_l[i]    = 1'b0;
                val[i]      = val[i] + 1;
                seen_cnt[i] = 0;
            end else if (req_seen[i]) begin
                seen_cnt[i]++;
                if (rnd_mode ? ($urandom_range(1, 0) == 1) : (delay[i] != 0 && seen_cnt[i] == delay[i])) begin
                    ack_l[i] = 1'b1;
                    sb_data.push_back(DW'(val[i]));
                    sb_src.push_back(SW'(i));
                end
            end else begin
                seen_cnt[i] = 0;
            end
        end
        req_seen = rst ? '0 : req_l;

        if (rst)              ack3 = '0;
        else if (ack3 != '0)  ack3 = '0;
        else                  ack3 = seen3;
        seen3 = rst ? '0 : req3;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int b0, c0, d0, f0, g0, n, held, v0;
    int exp_b[8] = '{0, 100, 200, 300, 1, 101, 201, 301};

    initial begin
        rst      = 1'b1;
        req_r    = 1'b1;
        rnd_mode = 1'b0;
        ack_l    = '0;
        ack3     = '0;
        seen3    = '0;
        din3     = {32'd7, 32'd5, 32'd3};
        for (int i = 0; i < NI; i++) begin
            val[i]      = 100 * i;
            delay[i]    = 1;
            seen_cnt[i] = 0;
            done_len[i] = 0;
        end
        tick(2);
        chk("reset_req_l", req_l, 0);
        chk("reset_ack_r", ack_r, 0);
        chk("reset_dout", dout, 0);
        chk("reset_dout_src", dout_src, 0);
        rst = 1'b0;

        b0 = got_data.size();
        tick(30);
        chk("b_count", got_data.size() - b0 >= 8, 1);
        if (got_data.size() - b0 >= 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("b_data", got_data[b0+k], exp_b[k]);
                chk("b_src", got_src[b0+k], k % 4);
            end
        end
        chk("b_ack_period", last_gap, 3);

        delay[2] = 0;
        c0 = got_data.size();
        tick(60);
        n = 0;
        for (int k = c0 + 2; k < got_data.size(); k++) if (got_src[k] == 2) n++;
        chk("c_no_src2", n, 0);
        chk("c_words", got_data.size() - c0 > 5, 1);
        chk("c_skip_len", done_len[2], 4);

        delay[2] = 1;
        delay[1] = 4;
        d0 = got_data.size();
        tick(40);
        n = 0;
        for (int k = d0 + 2; k < got_data.size(); k++) if (got_src[k] == 1) n++;
        chk("d_src1_seen", n > 0, 1);
        chk("d_grace_len", done_len[1], 4);

        delay[1] = 1;
        tick(6);
        req_r = 1'b0;
        tick(5);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("e_hold_ack_r", ack_r, 0);
            chk("e_hold_req_l", req_l, 0);
        end
        chk("e_held_depth", sb_data.size(), 1);
        held = (sb_data.size() > 0) ? int'(sb_data[0]) : -1;
        req_r = 1'b1;
        tick(1);
        chk("e_release_ack", ack_r, 1);
        chk("e_release_dout", dout, held);
        tick(1);
        chk("e_release_pulse", ack_r, 0);

        for (int i = 0; i < NI; i++) delay[i] = 0;
        tick(10);
        req_r    = 1'b0;
        val[1]   = 105;
        delay[1] = 1;
        tick(30);
        chk("f_held_depth", sb_data.size(), 1);
        chk("f_send_req_l", req_l, 0);
        rst = 1'b1;
        tick(1);
        chk("f_rst_req_l", req_l, 0);
        chk("f_rst_ack_r", ack_r, 0);
        chk("f_rst_dout", dout, 0);
        chk("f_rst_dout_src", dout_src, 0);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) delay[i] = 1;
        v0    = int'(val[0]);
        req_r = 1'b1;
        f0    = got_data.size();
        tick(12);
        chk("f_post_count", got_data.size() > f0, 1);
        if (got_data.size() > f0) begin
            chk("f_first_src", got_src[f0], 0);
            chk("f_first_data", got_data[f0], v0);
        end
        n = 0;
        for (int k = f0; k < got_data.size(); k++) if (got_data[k] == 105) n++;
        chk("f_no_105", n, 0);

        rnd_mode = 1'b1;
        g0 = got_data.size();
        tick(800);
        rnd_mode = 1'b0;
        tick(20);
        chk("g_words", got_data.size() - g0 > 100, 1);
        chk("g_drained", sb_data.size() <= 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_merge_arbiter.md
# rr_merge_arbiter

Round-robin N-to-1 merge scheduler for the asynchronous dataflow fabric. It shares one downstream consumer channel among `num_inputs` upstream operator outputs by polling each source in turn. It skips a source that fails to acknowledge within a bounded window. Upstream it acts as a requester, like an `async_operator` left side; downstream it acts as a responder, like a producer.

## Interface
- `data_width`, 32, width of each data word.
- `num_inputs`, 4, number of upstream channels; valid range 2..16.
- `src_width`, 2, width of the source index; must satisfy 2^src_width >= num_inputs.
- `timeout`, 4, maximum cycles spent requesting one source before skipping it; 0 means wait forever.

Ports:
- `clk`  in  1  clock; all logic uses the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_l`  out  num_inputs  one-hot request to upstream sources; registered.
- `ack_l`  in  num_inputs  per-source acknowledge pulse; data is valid in the same cycle.
- `din`  in  data_width*num_inputs  packed source data; source i occupies bits [data_width*(i+1)-1 : data_width*i].
- `req_r`  in  1  downstream request level.
- `ack_r`  out  1  downstream acknowledge; single-cycle pulse.
- `dout`  out  data_width  merged data word; registered, held until the next transfer.
- `dout_src`  out  src_width  index of the source that produced `dout`; registered with `dout`.

## Operation
- State machine states: IDLE, REQ, GRACE, SEND. Internal state:
  - `ptr`, the current source index.
  - `cnt`, a wait counter of at least 8 bits that saturates.
  - `buf`/`buf_src`, the holding register for one captured word.
- IDLE: entered only from reset. Next edge → REQ, and `req_l[ptr]` is set.
- REQ: `req_l` = onehot(ptr); `cnt` increments each cycle.
  - If `ack_l[ptr]` is high: capture `din` slice `ptr` into `buf`, set `buf_src` = ptr, clear `req_l`, go to SEND.
  - Otherwise, if timeout != 0 and `cnt` == timeout-1: clear `req_l`, go to GRACE.
- GRACE (exactly 1 cycle): catches a late ack from a source that sampled `req_l` before it dropped.
  - If `ack_l[ptr]` is high: capture as in REQ, go to SEND.
  - Otherwise: advance `ptr`, go to REQ with `req_l` set for the new `ptr`.
- SEND: if `req_r` is high and `ack_r` is low, then on the same edge:
  - `ack_r` <= 1, `dout` <= `buf`, `dout_src` <= `buf_src`;
  - advance `ptr`, clear `cnt`, go to REQ with `req_l[new ptr]` set.
  - Otherwise stay in SEND; `buf` is held indefinitely.
- Advancing `ptr` means ptr+1, wrapping from num_inputs-1 to 0. The power-of-two rollover is not used.
- `cnt` clears on every entry to REQ.
- `ack_r` defaults to 0 on every edge where it is not set, so it is a one-cycle pulse.
- `ack_l` on a non-selected index is ignored: no capture and no state change.
- At most one word is in flight; no FIFO.

## Timing
- Reset values: `req_l`=0, `ack_r`=0, `dout`=0, `dout_src`=0, `ptr`=0, `cnt`=0, state IDLE.
- Steady state with a zero-fail producer and consumer:
  - edge E0: enter REQ, `req_l[i]`=1;
  - E1: producer asserts ack;
  - E2: capture, go to SEND;
  - E3: `ack_r`=1 and REQ for source i+1.
- Throughput is 1 word per 3 cycles. Latency from `req_l` assertion to `ack_r` is 3 cycles.
- A skipped source costs timeout+1 cycles: timeout cycles in REQ plus one in GRACE.
- With timeout=0, REQ never exits without an ack.
- Reset mid-operation (any state): return to the reset values on that edge and discard `buf`. An `ack_l` arriving in the cycle after reset is ignored.
- `req_r` dropping while in SEND is legal: the state is held, no ack is issued, and no data is lost.

## Test plan
- num_inputs=4, four zero-fail producers with initial values 0/100/200/300, always-requesting consumer → consumer receives 0,100,200,300,1,101,… with `dout_src` 0,1,2,3,0,…; `ack_r` period is exactly 3 cycles.
- Source 2 never acks, timeout=4 → `req_l[2]` is high for exactly 4 cycles, then GRACE, then `req_l[3]`. The sequence skips src 2 and no value from source 2 appears.
- Source 1 acks on the first cycle of GRACE → the word is captured and `dout_src`=1. No duplicate word appears, and `ptr` advances to 2 only after SEND.
- Consumer holds `req_r`=0 for 10 cycles after a capture → `ack_r` stays 0 and `req_l` stays 0. On `req_r`=1, a single `ack_r` pulse occurs next edge with the held value.
- `rst` pulsed while in SEND holding 105 → all outputs are 0 next cycle and `ptr`=0. The first post-reset word comes from source 0, and 105 is never delivered.
- num_inputs=3, src_width=2 → `dout_src` cycles 0,1,2,0, never 3. With fail_rate 50 producers and 5000 words, no word is duplicated or dropped per source.
